// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader sitting in front of the 16-bit CPU. It takes a framed byte
//   stream from the host link, writes 16-bit instruction words into the
//   instruction memory write port and keeps the CPU in reset until a complete
//   frame with a matching XOR checksum has been stored.
//   Frame: 0xA5 | LEN_LO | LEN_HI | {W_LO, W_HI} x LEN | XOR of all bytes after 0xA5
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active low
//   start      : one-cycle pulse, arms the loader from IDLE/DONE/ERROR
//   byte_valid : byte_data holds a stream byte
//   byte_data  : stream byte
//   byte_ready : loader accepts a byte this cycle (registered state decode)
//   imem_we    : one-cycle instruction memory write strobe
//   imem_addr  : write address (BASE_ADDR + word index, wraps)
//   imem_wdata : instruction word {hi, lo}
//   cpu_rst    : active-high CPU reset, released only after a verified frame
//   done       : frame stored and checksum matched
//   error      : frame aborted (length too large, bad checksum, timeout)
//   word_count : words written in the current/last frame
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | after reset, waiting for start, stream not accepted
// SYNC    | hunting for 0xA5, other bytes dropped, no timeout
// LEN_LO  | waiting for low length byte
// LEN_HI  | waiting for high length byte, length range check
// DATA_LO | waiting for low byte of next word
// DATA_HI | waiting for high byte, word written the following cycle
// CHECK   | waiting for checksum byte
// DONE    | frame verified, CPU released
// ERROR   | frame aborted, CPU held in reset
module program_loader #(
  parameter int                ADDR_W      = 16,
  parameter int                MAX_WORDS   = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] word_count
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [16:0]      MAX_LEN  = 17'(MAX_WORDS);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic              byte_ready_q, byte_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [15:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] word_count_q, word_count_d;
  logic [7:0]        checksum_q, checksum_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [7:0]        data_lo_q, data_lo_d;
  logic [15:0]       words_left_q, words_left_d;

  logic        xfer;
  logic        timed;
  logic [15:0] len_rx;

  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    word_count_d = word_count_q;
    checksum_d   = checksum_q;
    len_lo_d     = len_lo_q;
    data_lo_d    = data_lo_q;
    words_left_d = words_left_q;
    cpu_rst_d    = cpu_rst_q;

    xfer   = byte_valid && byte_ready_q;
    len_rx = {byte_data, len_lo_q};
    timed  = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHECK};

    // Idle-cycle counter: restarts on every handshake, parked outside a frame.
    timer_d = '0;
    if (timed && !xfer) timer_d = timer_q + TMR_W'(1);

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (xfer && byte_data == 8'hA5) begin
          state_d      = S_LEN_LO;
          checksum_d   = 8'h00;
          word_count_d = '0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_lo_d   = byte_data;
          checksum_d = checksum_q ^ byte_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          checksum_d   = checksum_q ^ byte_data;
          words_left_d = len_rx;
          if ({1'b0, len_rx} > MAX_LEN) state_d = S_ERROR;
          else if (len_rx == 16'h0)     state_d = S_CHECK;
          else                          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          data_lo_d  = byte_data;
          checksum_d = checksum_q ^ byte_data;
          state_d    = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          checksum_d   = checksum_q ^ byte_data;
          imem_we_d    = 1'b1;
          imem_wdata_d = {byte_data, data_lo_q};
          imem_addr_d  = BASE_ADDR + word_count_q;
          word_count_d = word_count_q + ADDR_W'(1);
          words_left_d = words_left_q - 16'd1;
          state_d      = (words_left_q == 16'd1) ? S_CHECK : S_DATA_LO;
        end
      end
      S_CHECK: begin
        if (xfer) state_d = (byte_data == checksum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase

    // A handshake in the final allowed cycle still counts.
    if (timed && !xfer && timer_q == TMR_LAST) begin
      state_d = S_ERROR;
      timer_d = '0;
    end

    // Status flags are registered decodes of the next state, so the outputs
    // carry no combinational path from the stream inputs.
    byte_ready_d = state_d inside {S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHECK};
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERROR);
    if (state_d == S_DONE && state_q != S_DONE) cpu_rst_d = 1'b0;
    if (state_d == S_SYNC && state_q != S_SYNC) cpu_rst_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
      checksum_q   <= '0;
      timer_q      <= '0;
      len_lo_q     <= '0;
      data_lo_q    <= '0;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      error_q      <= error_d;
      word_count_q <= word_count_d;
      checksum_q   <= checksum_d;
      timer_q      <= timer_d;
      len_lo_q     <= len_lo_d;
      data_lo_q    <= data_lo_d;
      words_left_q <= words_left_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule
